// File: rtl/vga_tile_driver.sv
// VGA raster timing generator with tile-mapped VRAM address scan; sync/blank delay-matched to RGB.
// Optional blinking tile cursor compiled in with `define VGA_CURSOR_EN.
module vga_tile_driver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_SHIFT = 3,
    parameter int ADDR_W     = 13,
    parameter int COLOR_W    = 4,
    parameter int RD_LAT     = 1,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                   vga_clk,
    input  logic                   rst,
`ifdef VGA_CURSOR_EN
    input  logic [9:0]             cursor_x,
    input  logic [9:0]             cursor_y,
    input  logic [0:0]             cursor_en,
`endif
    input  logic [3*COLOR_W-1:0]   d_in,
    output logic [ADDR_W-1:0]      addr,
    output logic                   load_vram,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int TPR     = H_ACTIVE >> TILE_SHIFT;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } tap_t;

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 vis;
    logic                 cur_hit;
    logic                 frame_wrap;
    logic [31:0]          tile_col;
    logic [31:0]          tile_row;
    tap_t                 tap;
    tap_t [RD_LAT:0]      pipe;
    logic [RD_LAT-1:0]    cur_pipe;
    logic [3*COLOR_W-1:0] rgb_q;

    assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign vis       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign load_vram = vis;
    assign tile_col  = 32'(h_cnt) >> TILE_SHIFT;
    assign tile_row  = 32'(v_cnt) >> TILE_SHIFT;
    assign addr      = vis ? ADDR_W'(tile_row * 32'(TPR) + tile_col) : '0;

`ifdef VGA_CURSOR_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst)             frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 1'b1;
    end

    // frame_cnt[5] gives a 32-frames-on / 32-frames-off blink
    assign cur_hit = cursor_en[0] && frame_cnt[5] &&
                     (tile_col == 32'(cursor_x)) && (tile_row == 32'(cursor_y));
`else
    assign cur_hit = 1'b0;
`endif

    always_comb begin
        tap     = '0;
        tap.vis = vis;
        tap.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        tap.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        tap.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage k holds counter state from k+1 cycles ago; stage RD_LAT drives the pins.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            pipe     <= '0;
            cur_pipe <= '0;
        end else begin
            pipe[0]     <= tap;
            cur_pipe[0] <= cur_hit;
            for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
            for (int i = 1; i < RD_LAT; i++)  cur_pipe[i] <= cur_pipe[i-1];
        end
    end

    // d_in for state t arrives during t+RD_LAT, matching stage RD_LAT-1
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst)
            rgb_q <= '0;
        else if (pipe[RD_LAT-1].vis)
            rgb_q <= cur_pipe[RD_LAT-1] ? ~d_in : d_in;
        else
            rgb_q <= '0;
    end

    assign r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign g           = rgb_q[2*COLOR_W-1:COLOR_W];
    assign b           = rgb_q[COLOR_W-1:0];
    assign hs          = pipe[RD_LAT].hs ^ ~SYNC_POL;
    assign vs          = pipe[RD_LAT].vs ^ ~SYNC_POL;
    assign de          = pipe[RD_LAT].vis;
    assign frame_start = pipe[RD_LAT].fs;

endmodule

// File: tb/tb_vga_tile_driver.sv
// Directed bench for vga_tile_driver on a reduced 48x24 raster (32x16 visible, 8x8 tiles, RD_LAT=3).
// VRAM model returns addr[11:0] three cycles late, so rgb reveals the tile address of each pixel.
module tb_vga_tile_driver;
    localparam int RL = 3;

    logic        vga_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [11:0] d_in;
    logic [12:0] addr;
    logic        load_vram;
    logic [3:0]  r, g, b;
    logic        hs, vs, de, frame_start;
`ifdef VGA_CURSOR_EN
    logic [9:0]  cursor_x  = '0;
    logic [9:0]  cursor_y  = '0;
    logic [0:0]  cursor_en = '0;
`endif

    vga_tile_driver #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(8),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .TILE_SHIFT(3), .ADDR_W(13), .COLOR_W(4), .RD_LAT(RL), .SYNC_POL(1'b0)
    ) dut (
        .vga_clk(vga_clk), .rst(rst),
`ifdef VGA_CURSOR_EN
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
`endif
        .d_in(d_in), .addr(addr), .load_vram(load_vram),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    logic [12:0] dq0 = '0, dq1 = '0, dq2 = '0;
    always @(posedge vga_clk) begin
        dq0 <= addr;
        dq1 <= dq0;
        dq2 <= dq1;
    end
    assign d_in = dq2[11:0];

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic        ld, de, hs, vs, fs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic adv();
        @(negedge vga_clk);
        cyc++;
    endtask

    task automatic add(input int c, input logic [12:0] a, input logic ld, input logic d,
                       input logic h, input logic v, input logic f, input logic [11:0] rgb);
        vec_t e;
        e.cyc = c; e.addr = a; e.ld = ld; e.de = d; e.hs = h; e.vs = v; e.fs = f; e.rgb = rgb;
        tbl.push_back(e);
    endtask

    initial begin
        int de_n, hs_n, vs_n, fs_n, first_fs, stale;

        // cyc: counters at (cyc%48, cyc/48); outputs reflect state cyc-4
        //   cyc   addr ld de hs vs fs rgb
        add(0,    0,  1, 0, 1, 1, 0, 12'h000);
        add(3,    0,  1, 0, 1, 1, 0, 12'h000);
        add(4,    0,  1, 1, 1, 1, 1, 12'h000);
        add(5,    0,  1, 1, 1, 1, 0, 12'h000);
        add(12,   1,  1, 1, 1, 1, 0, 12'h001);
        add(31,   3,  1, 1, 1, 1, 0, 12'h003);
        add(32,   0,  0, 1, 1, 1, 0, 12'h003);
        add(36,   0,  0, 0, 1, 1, 0, 12'h000);
        add(40,   0,  0, 0, 0, 1, 0, 12'h000);
        add(43,   0,  0, 0, 0, 1, 0, 12'h000);
        add(44,   0,  0, 0, 1, 1, 0, 12'h000);
        add(388,  4,  1, 1, 1, 1, 0, 12'h004);
        add(452,  6,  1, 1, 1, 1, 0, 12'h006);
        add(751,  7,  1, 1, 1, 1, 0, 12'h007);
        add(768,  0,  0, 0, 1, 1, 0, 12'h000);
        add(868,  0,  0, 0, 1, 0, 0, 12'h000);
        add(964,  0,  0, 0, 1, 1, 0, 12'h000);
        add(1156, 0,  1, 1, 1, 1, 1, 12'h000);
        add(1157, 0,  1, 1, 1, 1, 0, 12'h000);

        repeat (10) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("rst_de",   de, 0);
        chk("rst_hs",   hs, 1);
        chk("rst_vs",   vs, 1);
        chk("rst_fs",   frame_start, 0);
        chk("rst_rgb",  {r, g, b}, 0);
        chk("rst_addr", addr, 0);

        @(posedge vga_clk);
        #1 rst = 1'b0;
        @(negedge vga_clk);
        cyc = 0;

        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) adv();
            chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
            chk($sformatf("v%0d_ld", i),   load_vram, tbl[i].ld);
            chk($sformatf("v%0d_de", i),   de, tbl[i].de);
            chk($sformatf("v%0d_hs", i),   hs, tbl[i].hs);
            chk($sformatf("v%0d_vs", i),   vs, tbl[i].vs);
            chk($sformatf("v%0d_fs", i),   frame_start, tbl[i].fs);
            chk($sformatf("v%0d_rgb", i),  {r, g, b}, tbl[i].rgb);
        end

        // one full frame of 1152 cycles: 32x16 de, 4 hs-low per line, 2 vs-low lines
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        repeat (1152) begin
            adv();
            de_n += int'(de);
            hs_n += int'(!hs);
            vs_n += int'(!vs);
            fs_n += int'(frame_start);
        end
        chk("frame_de_cnt", de_n, 512);
        chk("frame_hs_low", hs_n, 96);
        chk("frame_vs_low", vs_n, 96);
        chk("frame_fs_cnt", fs_n, 1);

        // mid-line reset at h=20, v=9 of the third frame
        while (cyc < 2304 + 452) adv();
        chk("pre_rst_de", de, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_de",   de, 0);
        chk("mid_rst_hs",   hs, 1);
        chk("mid_rst_vs",   vs, 1);
        chk("mid_rst_fs",   frame_start, 0);
        chk("mid_rst_rgb",  {r, g, b}, 0);
        chk("mid_rst_addr", addr, 0);
        repeat (3) @(posedge vga_clk);
        #1 rst = 1'b0;

        first_fs = -1;
        stale    = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge vga_clk);
            if (frame_start && first_fs < 0) first_fs = n;
            if (n < RL + 1 && de) stale++;
            if (!de && {r, g, b} != 12'h000) stale++;
        end
        chk("post_rst_fs_lat", first_fs, RL + 1);
        chk("post_rst_stale",  stale, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
